axis_tx_pkt_arbiter: RTL and testbench
======================================

Name: axis_tx_pkt_arbiter

Overview:
Packet-granular round-robin arbiter that shares one 512-bit AXI4-Stream TX path between NUM_PORTS requesters. Its output feeds the axis-to-LBUS converter ahead of the CMAC/Interlaken TX.
Once a port wins, it keeps the grant until its tlast beat is accepted, so packets never interleave.
The output is fully registered, giving a one-register stage toward the LBUS converter.

Parameters:
NUM_PORTS, 4, number of upstream AXI4-Stream requesters (1..16)
GW, $clog2(NUM_PORTS) floored at 1, width of grant index (derived, localparam)

Ports:
clk  in  1  single clock for all logic
rst_n  in  1  asynchronous, active-low reset
s_axis_tdata  in  NUM_PORTS*512  per-port data, port p at [p*512 +: 512]
s_axis_tkeep  in  NUM_PORTS*64  per-port byte enables, port p at [p*64 +: 64]
s_axis_tlast  in  NUM_PORTS  per-port end of packet
s_axis_tuser  in  NUM_PORTS  per-port error flag, passed through
s_axis_tvalid  in  NUM_PORTS  per-port valid
s_axis_tready  out  NUM_PORTS  per-port ready (one-hot or zero)
m_axis_tdata  out  512  arbitrated data
m_axis_tkeep  out  64  arbitrated byte enables
m_axis_tlast  out  1  arbitrated end of packet
m_axis_tuser  out  1  arbitrated error flag
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  downstream ready
grant_id  out  GW  index of the current or last granted port
busy  out  1  high while in state BUSY
pkt_cnt  out  32  packets forwarded (tlast beats accepted), wraps

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - All outputs 0: m_axis_*, s_axis_tready, grant_id, busy, pkt_cnt.
  - Internal last_grant = NUM_PORTS-1, so port 0 has first priority.
  - State = IDLE.
- State IDLE:
  - s_axis_tready = 0.
  - If any s_axis_tvalid is set, pick the first set index scanning last_grant+1, last_grant+2, ..., modulo NUM_PORTS.
  - Next edge: grant_id and last_grant take the winner, state = BUSY, busy = 1.
  - If no request, stay IDLE.
- State BUSY:
  - s_axis_tready[grant_id] = ~m_axis_tvalid | m_axis_tready (combinational). All other ready bits 0.
  - Load: on an input handshake, m_axis_tdata/tkeep/tlast/tuser take the granted port's beat and m_axis_tvalid = 1.
  - Drain: if m_axis_tready and no load, m_axis_tvalid = 0.
  - Hold: while m_axis_tvalid & ~m_axis_tready, all m_axis_* stay stable.
  - If the accepted input beat has tlast = 1: pkt_cnt increments by 1 (wraps 0xFFFFFFFF -> 0), and state = IDLE, busy = 0 at the next edge.
- Latency:
  - First beat: s_axis_tvalid high at cycle 0 in IDLE -> grant at edge 1 -> input handshake in cycle 1 -> m_axis_tvalid at edge 2.
  - Subsequent beats: 1 cycle input to output, 1 beat/cycle sustained while m_axis_tready is high.
- Inter-packet gap: exactly 1 IDLE cycle at the input side.
  - The output register may still hold the previous tlast beat during IDLE; it drains normally.
  - The new packet's first beat loads only after the old one is accepted.
- Mid-packet stall: if the granted port drops tvalid, the grant is held indefinitely. There is no timeout and no preemption.
- Non-granted ports may toggle tvalid freely; their state affects only the next arbitration.
- tkeep and tuser are passed unchecked; a single-beat packet (tlast on first beat) is legal.
- NUM_PORTS = 1: always grants port 0 and keeps the same timing.
- Reset mid-packet clears all state immediately. The partial packet is truncated downstream (no tlast); recovery is upstream's responsibility.

Test Plan:
- Single-packet latency: NUM_PORTS=4, only port 2 sends a 3-beat packet, m_axis_tready=1.
  - grant_id=2 after 1 cycle; m_axis_tvalid on cycles 2..4; tlast on the 3rd beat.
  - pkt_cnt=1; busy returns to 0.
- Round-robin rotation: all 4 ports continuously valid with 2-beat packets.
  - Grant order 0,1,2,3,0.
  - Output never interleaves ports (check data tags); 1-cycle gap between packets.
- Backpressure: port 0 sends 4 beats with m_axis_tready toggling 1,0,0,1,...
  - m_axis_* stable during stalls; s_axis_tready[0]=0 while the output is full and stalled; all 4 beats arrive in order.
- Mid-packet upstream stall: port 1 drops tvalid for 5 cycles after beat 1 while port 3 requests.
  - grant_id stays 1; port 3 is served only after port 1's tlast.
- Counter wrap: force pkt_cnt to 0xFFFFFFFF (or preload via 2^32 packets in a shortened sim), send one packet -> pkt_cnt=0.
- Async reset mid-packet: assert rst_n low between clock edges during beat 2.
  - All outputs 0 immediately; after release, port 0 wins the first arbitration.

Source files
------------

// File: rtl/axis_tx_pkt_arbiter.sv
// Packet-granular round-robin arbiter sharing one registered 512-bit AXI4-Stream TX path.
// A winning port keeps the grant until its tlast beat is accepted, so packets never interleave.
module axis_tx_pkt_arbiter #(
    parameter int unsigned NUM_PORTS = 4,
    localparam int unsigned GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_PORTS*512-1:0] s_axis_tdata,
    input  logic [NUM_PORTS*64-1:0]  s_axis_tkeep,
    input  logic [NUM_PORTS-1:0]     s_axis_tlast,
    input  logic [NUM_PORTS-1:0]     s_axis_tuser,
    input  logic [NUM_PORTS-1:0]     s_axis_tvalid,
    output logic [NUM_PORTS-1:0]     s_axis_tready,
    output logic [511:0]             m_axis_tdata,
    output logic [63:0]              m_axis_tkeep,
    output logic                     m_axis_tlast,
    output logic                     m_axis_tuser,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [GW-1:0]            grant_id,
    output logic                     busy,
    output logic [31:0]              pkt_cnt
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   last_grant_q, last_grant_d;
    logic            valid_q, valid_d;
    logic [511:0]    data_q, data_d;
    logic [63:0]     keep_q, keep_d;
    logic            last_q, last_d;
    logic            user_q, user_d;
    logic [31:0]     cnt_q, cnt_d;

    logic            arb_found;
    logic [GW-1:0]   arb_winner;
    int unsigned     arb_dist;
    int unsigned     arb_best;

    logic [511:0]    sel_data;
    logic [63:0]     sel_keep;
    logic            sel_last;
    logic            sel_user;
    logic            sel_valid;
    logic            ready_g;
    logic            hs;

    // Rotating priority: distance of each requester from last_grant+1, smallest wins.
    always_comb begin
        arb_found  = 1'b0;
        arb_winner = '0;
        arb_dist   = 0;
        arb_best   = NUM_PORTS;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            arb_dist = (p + NUM_PORTS - 1 - 32'(last_grant_q)) % NUM_PORTS;
            if (s_axis_tvalid[p] && (arb_dist < arb_best)) begin
                arb_best   = arb_dist;
                arb_winner = GW'(p);
                arb_found  = 1'b1;
            end
        end
    end

    assign sel_data  = s_axis_tdata[32'(grant_q) * 32'd512 +: 512];
    assign sel_keep  = s_axis_tkeep[32'(grant_q) * 32'd64 +: 64];
    assign sel_last  = s_axis_tlast[grant_q];
    assign sel_user  = s_axis_tuser[grant_q];
    assign sel_valid = s_axis_tvalid[grant_q];

    // Accept a new beat only when the output register is empty or being drained.
    assign ready_g = (state_q == StBusy) && (!valid_q || m_axis_tready);
    assign hs      = ready_g && sel_valid;

    always_comb begin
        s_axis_tready          = '0;
        s_axis_tready[grant_q] = ready_g;
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        valid_d      = valid_q;
        data_d       = data_q;
        keep_d       = keep_q;
        last_d       = last_q;
        user_d       = user_q;
        cnt_d        = cnt_q;
        case (state_q)
            StIdle: begin
                // The previous packet's tlast beat may still be waiting downstream.
                if (m_axis_tready) begin
                    valid_d = 1'b0;
                end
                if (arb_found) begin
                    grant_d      = arb_winner;
                    last_grant_d = arb_winner;
                    state_d      = StBusy;
                end
            end
            StBusy: begin
                if (hs) begin
                    valid_d = 1'b1;
                    data_d  = sel_data;
                    keep_d  = sel_keep;
                    last_d  = sel_last;
                    user_d  = sel_user;
                    if (sel_last) begin
                        cnt_d   = cnt_q + 32'd1;
                        state_d = StIdle;
                    end
                end else if (m_axis_tready) begin
                    valid_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            last_grant_q <= GW'(NUM_PORTS - 1);
            valid_q      <= 1'b0;
            data_q       <= '0;
            keep_q       <= '0;
            last_q       <= 1'b0;
            user_q       <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            valid_q      <= valid_d;
            data_q       <= data_d;
            keep_q       <= keep_d;
            last_q       <= last_d;
            user_q       <= user_d;
            cnt_q        <= cnt_d;
        end
    end

    assign m_axis_tdata  = data_q;
    assign m_axis_tkeep  = keep_q;
    assign m_axis_tlast  = last_q;
    assign m_axis_tuser  = user_q;
    assign m_axis_tvalid = valid_q;
    assign grant_id      = grant_q;
    assign busy          = (state_q == StBusy);
    assign pkt_cnt       = cnt_q;

endmodule

// File: tb/tb_axis_tx_pkt_arbiter.sv
// Self-checking bench for axis_tx_pkt_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level round-robin reference model.
module tb_axis_tx_pkt_arbiter;
    localparam int NP = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NP*512-1:0] s_axis_tdata = '0;
    logic [NP*64-1:0]  s_axis_tkeep = '0;
    logic [NP-1:0]     s_axis_tlast = '0;
    logic [NP-1:0]     s_axis_tuser = '0;
    logic [NP-1:0]     s_axis_tvalid = '0;
    logic [NP-1:0]     s_axis_tready;
    logic [511:0]      m_axis_tdata;
    logic [63:0]       m_axis_tkeep;
    logic              m_axis_tlast;
    logic              m_axis_tuser;
    logic              m_axis_tvalid;
    logic              m_axis_tready = 1'b0;
    logic [1:0]        grant_id;
    logic              busy;
    logic [31:0]       pkt_cnt;

    always #5 clk = ~clk;

    axis_tx_pkt_arbiter #(.NUM_PORTS(NP)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
        .s_axis_tuser(s_axis_tuser), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
        .m_axis_tuser(m_axis_tuser), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .grant_id(grant_id), .busy(busy), .pkt_cnt(pkt_cnt)
    );

    int errors = 0;
    int checks = 0;

    // Per-port source queues (circular, 64 beats each).
    logic [511:0] bd [NP][64];
    logic [63:0]  bk [NP][64];
    logic         bl [NP][64];
    logic         bu [NP][64];
    int head [NP];
    int tail [NP];
    int seq  [NP];
    int hold [NP];
    bit rand_gate = 0;
    int rdy_mode = 0;
    int pat = 0;
    bit stall_arm = 0;
    int stall_port = 0;
    int stall_at = 0;

    // Reference model: packet-level arbiter with a single-entry output buffer.
    bit           ref_busy;
    int           ref_grant;
    int           ref_last;
    logic         ref_valid;
    logic [511:0] ref_data;
    logic [63:0]  ref_keep;
    logic         ref_tlast;
    logic         ref_tuser;
    logic [31:0]  ref_cnt;

    task automatic model_reset();
        ref_busy = 0; ref_grant = 0; ref_last = NP - 1;
        ref_valid = 0; ref_data = '0; ref_keep = '0; ref_tlast = 0; ref_tuser = 0;
        ref_cnt = '0;
        for (int p = 0; p < NP; p++) begin
            head[p] = 0; tail[p] = 0; hold[p] = 0;
        end
        stall_arm = 0;
    endtask

    task automatic model_edge();
        int g;
        if (!ref_busy) begin
            if (ref_valid && m_axis_tready) ref_valid = 0;
            for (int k = 1; k <= NP; k++) begin
                if (!ref_busy && s_axis_tvalid[(ref_last + k) % NP]) begin
                    ref_grant = (ref_last + k) % NP;
                    ref_last  = ref_grant;
                    ref_busy  = 1;
                end
            end
        end else begin
            g = ref_grant;
            if ((!ref_valid || m_axis_tready) && s_axis_tvalid[g]) begin
                ref_valid = 1;
                ref_data  = s_axis_tdata[g*512 +: 512];
                ref_keep  = s_axis_tkeep[g*64 +: 64];
                ref_tlast = s_axis_tlast[g];
                ref_tuser = s_axis_tuser[g];
                head[g]++;
                if (s_axis_tlast[g]) begin
                    ref_cnt  = ref_cnt + 32'd1;
                    ref_busy = 0;
                end
            end else if (m_axis_tready) begin
                ref_valid = 0;
            end
        end
    endtask

    task automatic enqueue(input int p, input int n);
        logic [511:0] d;
        for (int b = 0; b < n; b++) begin
            for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom();
            d[511:504] = 8'(p);
            d[503:496] = 8'(seq[p]);
            d[495:488] = 8'(b);
            bd[p][tail[p] % 64] = d;
            bk[p][tail[p] % 64] = {$urandom(), $urandom()};
            bl[p][tail[p] % 64] = (b == n - 1);
            bu[p][tail[p] % 64] = 1'($urandom_range(0, 1));
            tail[p]++;
        end
        seq[p]++;
    endtask

    task automatic drive_inputs();
        for (int p = 0; p < NP; p++) begin
            logic v;
            if (stall_arm && p == stall_port && head[p] == stall_at) begin
                hold[p] = 5;
                stall_arm = 0;
            end
            v = (head[p] < tail[p]) && (hold[p] == 0);
            if (rand_gate && $urandom_range(0, 3) == 0) v = 0;
            if (hold[p] > 0) hold[p]--;
            s_axis_tvalid[p]          = v;
            s_axis_tdata[p*512 +: 512] = bd[p][head[p] % 64];
            s_axis_tkeep[p*64 +: 64]   = bk[p][head[p] % 64];
            s_axis_tlast[p]           = bl[p][head[p] % 64];
            s_axis_tuser[p]           = bu[p][head[p] % 64];
        end
        case (rdy_mode)
            0: m_axis_tready = 1'b1;
            1: begin
                m_axis_tready = (pat % 3 == 0);
                pat++;
            end
            default: m_axis_tready = 1'($urandom_range(0, 1));
        endcase
    endtask

    // Edge, model update, new inputs at +1, leaves time at +2 for sampling.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        drive_inputs();
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        s_axis_tvalid = '0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        model_reset();
        #12;
        checks += 9;
        if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); end
        if (m_axis_tdata !== '0) begin errors++; $display("FAIL reset_tdata: got %h want 0", m_axis_tdata); end
        if (m_axis_tkeep !== '0) begin errors++; $display("FAIL reset_tkeep: got %h want 0", m_axis_tkeep); end
        if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b want 0", m_axis_tlast); end
        if (m_axis_tuser !== 1'b0) begin errors++; $display("FAIL reset_tuser: got %b want 0", m_axis_tuser); end
        if (s_axis_tready !== '0) begin errors++; $display("FAIL reset_sready: got %b want 0", s_axis_tready); end
        if (grant_id !== '0) begin errors++; $display("FAIL reset_grant: got %0d want 0", grant_id); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (pkt_cnt !== '0) begin errors++; $display("FAIL reset_pkt_cnt: got %0d want 0", pkt_cnt); end
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    task automatic test_single_latency();
        rdy_mode = 0; rand_gate = 0;
        enqueue(2, 3);
        drive_inputs();
        for (int k = 1; k <= 7; k++) begin
            cycle();
            if (k == 1) begin
                checks += 3;
                if (grant_id !== 2'd2) begin errors++; $display("FAIL lat_grant: got %0d want 2", grant_id); end
                if (busy !== 1'b1) begin errors++; $display("FAIL lat_busy: got %b want 1", busy); end
                if (s_axis_tready !== 4'b0100) begin errors++; $display("FAIL lat_sready: got %b want 0100", s_axis_tready); end
            end
            checks++;
            if (m_axis_tvalid !== (k >= 2 && k <= 4)) begin
                errors++; $display("FAIL lat_tvalid cycle %0d: got %b want %b", k, m_axis_tvalid, (k >= 2 && k <= 4));
            end
            if (k >= 2 && k <= 4) begin
                checks += 3;
                if (m_axis_tlast !== (k == 4)) begin errors++; $display("FAIL lat_tlast cycle %0d: got %b want %b", k, m_axis_tlast, (k == 4)); end
                if (m_axis_tdata[495:488] !== 8'(k - 2)) begin errors++; $display("FAIL lat_beat cycle %0d: got %0d want %0d", k, m_axis_tdata[495:488], k - 2); end
                if (m_axis_tdata !== ref_data) begin errors++; $display("FAIL lat_tdata cycle %0d: got %h want %h", k, m_axis_tdata, ref_data); end
            end
        end
        checks += 2;
        if (pkt_cnt !== 32'd1) begin errors++; $display("FAIL lat_pkt_cnt: got %0d want 1", pkt_cnt); end
        if (busy !== 1'b0) begin errors++; $display("FAIL lat_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_round_robin();
        int got[$];
        int idle_run;
        bit prev_busy;
        bit in_pkt;
        logic [7:0] cur_port;
        apply_reset();
        rdy_mode = 0; rand_gate = 0;
        for (int r = 0; r < 2; r++) for (int p = 0; p < NP; p++) enqueue(p, 2);
        drive_inputs();
        prev_busy = 0; idle_run = 0; in_pkt = 0; cur_port = '0;
        for (int c = 0; c < 60; c++) begin
            cycle();
            if (busy && !prev_busy) begin
                if (got.size() > 0) begin
                    checks++;
                    if (idle_run != 1) begin errors++; $display("FAIL rr_gap: got %0d idle cycles want 1", idle_run); end
                end
                got.push_back(int'(grant_id));
                idle_run = 0;
            end
            if (!busy) idle_run++;
            prev_busy = busy;
            if (m_axis_tvalid && m_axis_tready) begin
                checks += 2;
                if (in_pkt && m_axis_tdata[511:504] !== cur_port) begin
                    errors++; $display("FAIL rr_interleave: got port %0d want %0d", m_axis_tdata[511:504], cur_port);
                end
                if (m_axis_tdata !== ref_data) begin errors++; $display("FAIL rr_tdata: got %h want %h", m_axis_tdata, ref_data); end
                cur_port = m_axis_tdata[511:504];
                in_pkt = !m_axis_tlast;
            end
        end
        checks++;
        if (got.size() != 8) begin
            errors++; $display("FAIL rr_count: got %0d grants want 8", got.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (got[i] != i % NP) begin errors++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, got[i], i % NP); end
            end
        end
    endtask

    task automatic test_backpressure();
        int exp_idx;
        bit prev_stall;
        logic [511:0] pd;
        logic [63:0] pk;
        logic pl, pu;
        rdy_mode = 1; pat = 0; rand_gate = 0;
        enqueue(0, 4);
        drive_inputs();
        exp_idx = 0; prev_stall = 0; pd = '0; pk = '0; pl = 0; pu = 0;
        for (int c = 0; c < 40 && exp_idx < 4; c++) begin
            cycle();
            if (prev_stall) begin
                checks++;
                if (!m_axis_tvalid || m_axis_tdata !== pd || m_axis_tkeep !== pk ||
                    m_axis_tlast !== pl || m_axis_tuser !== pu) begin
                    errors++; $display("FAIL bp_stable: got v=%b d=%h want held d=%h", m_axis_tvalid, m_axis_tdata, pd);
                end
            end
            if (m_axis_tvalid && !m_axis_tready) begin
                checks++;
                if (s_axis_tready !== '0) begin errors++; $display("FAIL bp_sready: got %b want 0000", s_axis_tready); end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                checks++;
                if (m_axis_tdata[511:504] !== 8'd0 || m_axis_tdata[495:488] !== 8'(exp_idx)) begin
                    errors++; $display("FAIL bp_order: got port %0d beat %0d want port 0 beat %0d",
                                       m_axis_tdata[511:504], m_axis_tdata[495:488], exp_idx);
                end
                exp_idx++;
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            pd = m_axis_tdata; pk = m_axis_tkeep; pl = m_axis_tlast; pu = m_axis_tuser;
        end
        checks++;
        if (exp_idx != 4) begin errors++; $display("FAIL bp_count: got %0d beats want 4", exp_idx); end
        rdy_mode = 0;
        repeat (3) cycle();
    endtask

    task automatic test_mid_stall();
        int got[$];
        bit prev_busy;
        rdy_mode = 0; rand_gate = 0;
        enqueue(1, 3);
        enqueue(3, 1);
        stall_arm = 1; stall_port = 1; stall_at = head[1] + 1;
        drive_inputs();
        prev_busy = 0;
        for (int c = 0; c < 40; c++) begin
            cycle();
            if (busy && !prev_busy) got.push_back(int'(grant_id));
            prev_busy = busy;
            if (got.size() == 1 && busy) begin
                checks += 2;
                if (grant_id !== 2'd1) begin errors++; $display("FAIL stall_grant: got %0d want 1", grant_id); end
                if (s_axis_tready[3] !== 1'b0) begin errors++; $display("FAIL stall_sready3: got %b want 0", s_axis_tready[3]); end
            end
        end
        checks++;
        if (got.size() != 2) begin
            errors++; $display("FAIL stall_count: got %0d grants want 2", got.size());
        end else begin
            checks++;
            if (got[0] != 1 || got[1] != 3) begin
                errors++; $display("FAIL stall_order: got %0d,%0d want 1,3", got[0], got[1]);
            end
        end
    endtask

    task automatic test_counter_wrap();
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_q;
        ref_cnt = 32'hFFFF_FFFF;
        enqueue(2, 1);
        drive_inputs();
        repeat (6) cycle();
        checks += 2;
        if (pkt_cnt !== 32'd0) begin errors++; $display("FAIL wrap_pkt_cnt: got %h want 0", pkt_cnt); end
        if (ref_cnt !== pkt_cnt) begin errors++; $display("FAIL wrap_model_cnt: got %h want %h", pkt_cnt, ref_cnt); end
    endtask

    task automatic test_async_reset();
        int got[$];
        bit prev_busy;
        int c;
        rdy_mode = 0; rand_gate = 0;
        enqueue(1, 3);
        drive_inputs();
        c = 0;
        while (!m_axis_tvalid && c < 10) begin
            cycle();
            c++;
        end
        checks++;
        if (!m_axis_tvalid) begin errors++; $display("FAIL areset_start: got tvalid %b want 1", m_axis_tvalid); end
        #1;
        rst_n = 1'b0;
        #1;
        checks += 7;
        if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL areset_tvalid: got %b want 0", m_axis_tvalid); end
        if (m_axis_tdata !== '0) begin errors++; $display("FAIL areset_tdata: got %h want 0", m_axis_tdata); end
        if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL areset_tlast: got %b want 0", m_axis_tlast); end
        if (s_axis_tready !== '0) begin errors++; $display("FAIL areset_sready: got %b want 0", s_axis_tready); end
        if (grant_id !== '0) begin errors++; $display("FAIL areset_grant: got %0d want 0", grant_id); end
        if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy: got %b want 0", busy); end
        if (pkt_cnt !== '0) begin errors++; $display("FAIL areset_pkt_cnt: got %0d want 0", pkt_cnt); end
        s_axis_tvalid = '0;
        model_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        enqueue(3, 1);
        enqueue(0, 1);
        drive_inputs();
        prev_busy = 0;
        for (int k = 0; k < 12; k++) begin
            cycle();
            if (busy && !prev_busy) got.push_back(int'(grant_id));
            prev_busy = busy;
        end
        checks++;
        if (got.size() != 2 || got[0] != 0 || got[1] != 3) begin
            errors++; $display("FAIL areset_first_grant: got %0d grants first %0d want 2 grants 0 then 3",
                               got.size(), (got.size() > 0) ? got[0] : -1);
        end
    endtask

    task automatic test_random();
        logic [NP-1:0] er;
        int c;
        rdy_mode = 2; rand_gate = 1;
        for (int i = 0; i < 700; i++) begin
            for (int p = 0; p < NP; p++) begin
                if (tail[p] - head[p] < 50 && $urandom_range(0, 15) == 0) enqueue(p, $urandom_range(1, 4));
            end
            cycle();
            er = '0;
            if (ref_busy && (!ref_valid || m_axis_tready)) er[ref_grant] = 1'b1;
            checks += 9;
            if (m_axis_tvalid !== ref_valid) begin errors++; $display("FAIL rnd_tvalid @%0d: got %b want %b", i, m_axis_tvalid, ref_valid); end
            if (m_axis_tdata !== ref_data) begin errors++; $display("FAIL rnd_tdata @%0d: got %h want %h", i, m_axis_tdata, ref_data); end
            if (m_axis_tkeep !== ref_keep) begin errors++; $display("FAIL rnd_tkeep @%0d: got %h want %h", i, m_axis_tkeep, ref_keep); end
            if (m_axis_tlast !== ref_tlast) begin errors++; $display("FAIL rnd_tlast @%0d: got %b want %b", i, m_axis_tlast, ref_tlast); end
            if (m_axis_tuser !== ref_tuser) begin errors++; $display("FAIL rnd_tuser @%0d: got %b want %b", i, m_axis_tuser, ref_tuser); end
            if (s_axis_tready !== er) begin errors++; $display("FAIL rnd_sready @%0d: got %b want %b", i, s_axis_tready, er); end
            if (grant_id !== 2'(ref_grant)) begin errors++; $display("FAIL rnd_grant @%0d: got %0d want %0d", i, grant_id, ref_grant); end
            if (busy !== ref_busy) begin errors++; $display("FAIL rnd_busy @%0d: got %b want %b", i, busy, ref_busy); end
            if (pkt_cnt !== ref_cnt) begin errors++; $display("FAIL rnd_pkt_cnt @%0d: got %0d want %0d", i, pkt_cnt, ref_cnt); end
        end
        rand_gate = 0; rdy_mode = 0;
        c = 0;
        while (c < 600 && (ref_busy || ref_valid || head[0] < tail[0] || head[1] < tail[1] ||
                           head[2] < tail[2] || head[3] < tail[3])) begin
            cycle();
            c++;
        end
        checks += 3;
        if (ref_busy || ref_valid) begin errors++; $display("FAIL rnd_drain: got busy=%b valid=%b want idle", ref_busy, ref_valid); end
        if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rnd_drain_tvalid: got %b want 0", m_axis_tvalid); end
        if (pkt_cnt !== ref_cnt) begin errors++; $display("FAIL rnd_drain_cnt: got %0d want %0d", pkt_cnt, ref_cnt); end
    endtask

    initial begin
        for (int p = 0; p < NP; p++) seq[p] = 0;
        test_reset();
        test_single_latency();
        test_round_robin();
        test_backpressure();
        test_mid_stall();
        test_counter_wrap();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
